// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - default sizes and the legal-address predicate for the register file
package reg_file_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam logic [31:0] ZERO_ADDR = '0;

  // True when addr names a real register that is allowed to hold data.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] depth,
                                      input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == ZERO_ADDR));
  endfunction

endpackage

// File: rtl/reg_en_ff.sv
// rtl/reg_en_ff.sv - enable flop with async active-low reset and synchronous clear
module reg_en_ff #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/reg_file_bank.sv
// rtl/reg_file_bank.sv - 1W/2R register file with zero register, bypass and optional registered read
module reg_file_bank
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int RD_REG   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic              rd_valid
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] word_we;
  logic             wr_legal;
  logic [WIDTH-1:0] rval1;
  logic [WIDTH-1:0] rval2;

  assign wr_legal = we && addr_legal(32'(wa), 32'(DEPTH), ZERO_REG != 0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    assign word_we[i] = wr_legal && (wa == ADDR_W'(i));

    reg_en_ff #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .en    (word_we[i]),
      .d     (wd),
      .q     (mem[i])
    );
  end

  // Out-of-range and zero-register reads return 0; a legal same-cycle write wins over storage.
  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (addr_legal(32'(a), 32'(DEPTH), ZERO_REG != 0)) begin
      if ((BYPASS != 0) && wr_legal && (wa == a))
        v = wd;
      else
        v = mem[a];
    end
    return v;
  endfunction

  always_comb begin
    rval1 = read_port(ra1);
    rval2 = read_port(ra2);
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic valid_q;

    reg_en_ff #(.WIDTH(WIDTH)) u_rd1 (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .en    (re),
      .d     (rval1),
      .q     (rd1)
    );

    reg_en_ff #(.WIDTH(WIDTH)) u_rd2 (
      .clk   (clk),
      .reset (reset),
      .clr   (clear),
      .en    (re),
      .d     (rval2),
      .q     (rd2)
    );

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        valid_q <= 1'b0;
      else if (clear)
        valid_q <= 1'b0;
      else
        valid_q <= re;
    end

    assign rd_valid = valid_q;
  end else begin : g_rd_comb
    logic unused_re;
    assign unused_re = re;
    assign rd1       = rval1;
    assign rd2       = rval2;
    assign rd_valid  = 1'b1;
  end

endmodule

// File: tb/tb_reg_file_bank.sv
// tb/tb_reg_file_bank.sv - directed self-checking bench for reg_file_bank across four configurations
module tb_reg_file_bank;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        we;
  logic        re;
  logic [4:0]  wa;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] wd;

  logic [31:0] a_rd1, a_rd2, b_rd1, b_rd2, c_rd1, c_rd2, d_rd1, d_rd2;
  logic        a_v, b_v, c_v, d_v;

  int checks = 0;
  int errors = 0;

  // a: zero reg, bypass, comb read
  reg_file_bank #(.DEPTH(32), .ZERO_REG(1), .BYPASS(1), .RD_REG(0)) u_a (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wa(wa), .wd(wd), .re(re),
    .ra1(ra1), .ra2(ra2), .rd1(a_rd1), .rd2(a_rd2), .rd_valid(a_v));
  // b: no zero reg, no bypass, comb read
  reg_file_bank #(.DEPTH(32), .ZERO_REG(0), .BYPASS(0), .RD_REG(0)) u_b (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wa(wa), .wd(wd), .re(re),
    .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2), .rd_valid(b_v));
  // c: zero reg, bypass, registered read
  reg_file_bank #(.DEPTH(32), .ZERO_REG(1), .BYPASS(1), .RD_REG(1)) u_c (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wa(wa), .wd(wd), .re(re),
    .ra1(ra1), .ra2(ra2), .rd1(c_rd1), .rd2(c_rd2), .rd_valid(c_v));
  // d: 24 words, zero reg, no bypass, registered read
  reg_file_bank #(.DEPTH(24), .ZERO_REG(1), .BYPASS(0), .RD_REG(1)) u_d (
    .clk(clk), .reset(reset), .clear(clear), .we(we), .wa(wa), .wd(wd), .re(re),
    .ra1(ra1), .ra2(ra2), .rd1(d_rd1), .rd2(d_rd2), .rd_valid(d_v));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (a_rd1 !== 32'h0) begin errors++; $display("FAIL reset_a_rd1: got %h want %h", a_rd1, 32'h0); end
    checks++; if (c_rd1 !== 32'h0) begin errors++; $display("FAIL reset_c_rd1: got %h want %h", c_rd1, 32'h0); end
    checks++; if (c_v !== 1'b0) begin errors++; $display("FAIL reset_c_valid: got %b want 0", c_v); end
    checks++; if (d_v !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b want 0", d_v); end
    checks++; if (b_v !== 1'b1) begin errors++; $display("FAIL comb_valid_tied: got %b want 1", b_v); end
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_zero_reg;
    we = 1'b1; wa = 5'd0; wd = 32'hDEADBEEF;
    tick();
    we = 1'b0; ra1 = 5'd0;
    #1;
    checks++; if (a_rd1 !== 32'h0) begin errors++; $display("FAIL zero_reg_on: got %h want %h", a_rd1, 32'h0); end
    checks++; if (b_rd1 !== 32'hDEADBEEF) begin errors++; $display("FAIL zero_reg_off: got %h want %h", b_rd1, 32'hDEADBEEF); end
  endtask

  task automatic test_write_all;
    logic [31:0] e1, e2;
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'h1000_0000 + 32'(i);
      tick();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i); ra2 = 5'(31 - i);
      @(negedge clk);
      e1 = (i == 0) ? 32'h0 : 32'h1000_0000 + 32'(i);
      e2 = (i == 31) ? 32'h0 : 32'h1000_0000 + 32'(31 - i);
      checks++; if (a_rd1 !== e1) begin errors++; $display("FAIL all_a_rd1[%0d]: got %h want %h", i, a_rd1, e1); end
      checks++; if (a_rd2 !== e2) begin errors++; $display("FAIL all_a_rd2[%0d]: got %h want %h", i, a_rd2, e2); end
      e1 = (i == 0) ? 32'hDEADBEEF : e1;
      e2 = (i == 31) ? 32'hDEADBEEF : e2;
      checks++; if (b_rd1 !== e1) begin errors++; $display("FAIL all_b_rd1[%0d]: got %h want %h", i, b_rd1, e1); end
      checks++; if (b_rd2 !== e2) begin errors++; $display("FAIL all_b_rd2[%0d]: got %h want %h", i, b_rd2, e2); end
    end
    ra1 = 5'd12; ra2 = 5'd12;
    @(negedge clk);
    checks++; if (a_rd1 !== a_rd2 || a_rd1 !== 32'h1000_000C) begin errors++; $display("FAIL same_addr: got %h/%h want %h", a_rd1, a_rd2, 32'h1000_000C); end
    tick();
  endtask

  task automatic test_bypass;
    we = 1'b1; wa = 5'd7; wd = 32'h0000_00AA;
    tick();
    wd = 32'h0000_00BB; ra1 = 5'd7;
    #1;
    checks++; if (a_rd1 !== 32'h0000_00BB) begin errors++; $display("FAIL bypass_on: got %h want %h", a_rd1, 32'h0000_00BB); end
    checks++; if (b_rd1 !== 32'h0000_00AA) begin errors++; $display("FAIL bypass_off_same: got %h want %h", b_rd1, 32'h0000_00AA); end
    tick();
    we = 1'b0;
    #1;
    checks++; if (b_rd1 !== 32'h0000_00BB) begin errors++; $display("FAIL bypass_off_next: got %h want %h", b_rd1, 32'h0000_00BB); end
  endtask

  task automatic test_registered_read;
    we = 1'b1; wa = 5'd3; wd = 32'h33;
    tick();
    we = 1'b0; re = 1'b1; ra1 = 5'd3;
    tick();
    checks++; if (c_rd1 !== 32'h33) begin errors++; $display("FAIL rdreg_data: got %h want %h", c_rd1, 32'h33); end
    checks++; if (c_v !== 1'b1) begin errors++; $display("FAIL rdreg_valid: got %b want 1", c_v); end
    re = 1'b0; ra1 = 5'd4;
    tick();
    checks++; if (c_rd1 !== 32'h33) begin errors++; $display("FAIL rdreg_hold: got %h want %h", c_rd1, 32'h33); end
    checks++; if (c_v !== 1'b0) begin errors++; $display("FAIL rdreg_valid_low: got %b want 0", c_v); end
  endtask

  task automatic test_back_to_back;
    re = 1'b1; ra1 = 5'd4; ra2 = 5'd5;
    tick();
    checks++; if (c_rd1 !== 32'h1000_0004) begin errors++; $display("FAIL b2b_first: got %h want %h", c_rd1, 32'h1000_0004); end
    // Collision at this edge: bypass captures new data, non-bypass captures old.
    we = 1'b1; wa = 5'd9; wd = 32'h99; ra1 = 5'd9;
    tick();
    we = 1'b0; re = 1'b0;
    checks++; if (c_v !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", c_v); end
    checks++; if (c_rd1 !== 32'h99) begin errors++; $display("FAIL collide_bypass: got %h want %h", c_rd1, 32'h99); end
    checks++; if (d_rd1 !== 32'h1000_0009) begin errors++; $display("FAIL collide_nobypass: got %h want %h", d_rd1, 32'h1000_0009); end
    checks++; if (d_rd2 !== 32'h1000_0005) begin errors++; $display("FAIL b2b_rd2: got %h want %h", d_rd2, 32'h1000_0005); end
  endtask

  task automatic test_clear;
    clear = 1'b1; we = 1'b1; wa = 5'd5; wd = 32'h55; re = 1'b1; ra1 = 5'd5;
    tick();
    clear = 1'b0; we = 1'b0; re = 1'b0;
    checks++; if (c_rd1 !== 32'h0) begin errors++; $display("FAIL clear_c_rd1: got %h want %h", c_rd1, 32'h0); end
    checks++; if (c_v !== 1'b0) begin errors++; $display("FAIL clear_c_valid: got %b want 0", c_v); end
    checks++; if (d_rd2 !== 32'h0) begin errors++; $display("FAIL clear_d_rd2: got %h want %h", d_rd2, 32'h0); end
    checks++; if (b_rd1 !== 32'h0) begin errors++; $display("FAIL clear_reg5: got %h want %h", b_rd1, 32'h0); end
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      #1;
      checks++; if (b_rd1 !== 32'h0) begin errors++; $display("FAIL clear_all[%0d]: got %h want %h", i, b_rd1, 32'h0); end
    end
    tick();
  endtask

  task automatic test_out_of_range;
    we = 1'b1; wa = 5'd30; wd = 32'h3030_3030;
    tick();
    wa = 5'd20; wd = 32'h20;
    tick();
    we = 1'b0; re = 1'b1; ra1 = 5'd30; ra2 = 5'd20;
    tick();
    re = 1'b0;
    checks++; if (d_rd1 !== 32'h0) begin errors++; $display("FAIL oor_read: got %h want %h", d_rd1, 32'h0); end
    checks++; if (d_rd2 !== 32'h20) begin errors++; $display("FAIL oor_inrange: got %h want %h", d_rd2, 32'h20); end
    checks++; if (d_v !== 1'b1) begin errors++; $display("FAIL oor_valid: got %b want 1", d_v); end
    checks++; if (a_rd1 !== 32'h3030_3030) begin errors++; $display("FAIL depth32_reg30: got %h want %h", a_rd1, 32'h3030_3030); end
    re = 1'b1; ra1 = 5'd6; ra2 = 5'd14;
    tick();
    re = 1'b0;
    checks++; if (d_rd1 !== 32'h0) begin errors++; $display("FAIL oor_alias6: got %h want %h", d_rd1, 32'h0); end
    checks++; if (d_rd2 !== 32'h0) begin errors++; $display("FAIL oor_alias14: got %h want %h", d_rd2, 32'h0); end
  endtask

  task automatic test_async_reset;
    re = 1'b1; ra1 = 5'd20; ra2 = 5'd20;
    tick();
    re = 1'b0;
    checks++; if (d_rd1 !== 32'h20 || c_v !== 1'b1) begin errors++; $display("FAIL pre_reset: got %h/%b want %h/1", d_rd1, c_v, 32'h20); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (a_rd1 !== 32'h0) begin errors++; $display("FAIL areset_a_rd1: got %h want %h", a_rd1, 32'h0); end
    checks++; if (b_rd2 !== 32'h0) begin errors++; $display("FAIL areset_b_rd2: got %h want %h", b_rd2, 32'h0); end
    checks++; if (c_rd1 !== 32'h0) begin errors++; $display("FAIL areset_c_rd1: got %h want %h", c_rd1, 32'h0); end
    checks++; if (c_v !== 1'b0) begin errors++; $display("FAIL areset_c_valid: got %b want 0", c_v); end
    checks++; if (d_rd1 !== 32'h0) begin errors++; $display("FAIL areset_d_rd1: got %h want %h", d_rd1, 32'h0); end
    checks++; if (d_rd2 !== 32'h0) begin errors++; $display("FAIL areset_d_rd2: got %h want %h", d_rd2, 32'h0); end
    checks++; if (d_v !== 1'b0) begin errors++; $display("FAIL areset_d_valid: got %b want 0", d_v); end
    #2;
    reset = 1'b1;
    we = 1'b1; wa = 5'd2; wd = 32'h22;
    tick();
    we = 1'b0; ra1 = 5'd2; ra2 = 5'd30;
    #1;
    checks++; if (a_rd1 !== 32'h22) begin errors++; $display("FAIL first_write: got %h want %h", a_rd1, 32'h22); end
    checks++; if (a_rd2 !== 32'h0) begin errors++; $display("FAIL reset_storage: got %h want %h", a_rd2, 32'h0); end
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; we = 1'b0; re = 1'b0;
    wa = '0; ra1 = '0; ra2 = '0; wd = '0;
    test_reset();
    test_zero_reg();
    test_write_all();
    test_bypass();
    test_registered_read();
    test_back_to_back();
    test_clear();
    test_out_of_range();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
